// File: rtl/sdram_bank_tracker.sv
// sdram_bank_tracker: per-bank open-row and ACT/RD-WR/PRE timing legality tracker.
// Define SDRAM_BANK_TRACKER_ERR_EN to add the sticky err_o protocol checker.
module sdram_bank_tracker #(
    parameter int BANKS    = 4,
    parameter int ROW_BITS = 13
) (
    input  logic                     HCLK,
    input  logic                     HRESETn,
    input  logic [4:0]               cmd_i,
    input  logic [$clog2(BANKS)-1:0] cmd_bank_i,
    input  logic [ROW_BITS-1:0]      cmd_row_i,
    input  logic                     cmd_a10_i,
    input  logic [3:0]               tRCD_i,
    input  logic [3:0]               tRAS_i,
    input  logic [3:0]               tRP_i,
    input  logic [3:0]               tRC_i,
    input  logic [3:0]               tDAL_i,
    input  logic [$clog2(BANKS)-1:0] q_bank_i,
    input  logic [ROW_BITS-1:0]      q_row_i,
    output logic                     q_row_hit_o,
    output logic                     q_act_ok_o,
    output logic                     q_rw_ok_o,
    output logic                     q_pre_ok_o,
    output logic [BANKS-1:0]         bank_active_o,
    output logic                     all_idle_o
`ifdef SDRAM_BANK_TRACKER_ERR_EN
    ,
    output logic                     err_o
`endif
);
    // Loading max(t,1)-1 and saturating decrement are the same operation.
    function automatic logic [3:0] dec(input logic [3:0] c);
        return (c == 4'd0) ? 4'd0 : c - 4'd1;
    endfunction

    logic                cs, is_act, is_rw, is_pre, is_ref;
    logic [BANKS-1:0]    active, act_ok, rw_ok, pre_ok, ras_busy, tgt, opening, close_pre, close_ap;
    logic [ROW_BITS-1:0] row [BANKS];
    logic [3:0]          rcd [BANKS];
    logic [3:0]          ras [BANKS];
    logic [3:0]          rp  [BANKS];
    logic [3:0]          rc  [BANKS];

    assign cs     = cmd_i[4:3] == 2'b10;
    assign is_act = cs && cmd_i[2:0] == 3'b011;
    assign is_rw  = cs && cmd_i[2:1] == 2'b10;
    assign is_pre = cs && cmd_i[2:0] == 3'b010;
    assign is_ref = cs && cmd_i[2:0] == 3'b001;

    assign tgt       = BANKS'(1) << cmd_bank_i;
    assign opening   = is_act ? tgt : '0;
    assign close_pre = is_pre ? (cmd_a10_i ? active : tgt & active) : '0;
    assign close_ap  = (is_rw && cmd_a10_i) ? tgt : '0;

    always_comb begin
        act_ok   = '0;
        rw_ok    = '0;
        ras_busy = '0;
        for (int b = 0; b < BANKS; b++) begin
            act_ok[b]   = !active[b] && rp[b] == 4'd0 && rc[b] == 4'd0;
            rw_ok[b]    = active[b] && rcd[b] == 4'd0;
            ras_busy[b] = active[b] && ras[b] != 4'd0;
        end
    end
    assign pre_ok = ~ras_busy;

    assign q_row_hit_o   = active[q_bank_i] && row[q_bank_i] == q_row_i;
    assign q_act_ok_o    = act_ok[q_bank_i];
    assign q_rw_ok_o     = rw_ok[q_bank_i];
    assign q_pre_ok_o    = pre_ok[q_bank_i];
    assign bank_active_o = active;
    assign all_idle_o    = ~|active;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            active <= '0;
            for (int b = 0; b < BANKS; b++) begin
                row[b] <= '0;
                rcd[b] <= '0;
                ras[b] <= '0;
                rp[b]  <= '0;
                rc[b]  <= '0;
            end
        end else begin
            active <= opening | (active & ~close_pre & ~close_ap);
            for (int b = 0; b < BANKS; b++) begin
                row[b] <= opening[b] ? cmd_row_i : row[b];
                rcd[b] <= opening[b] ? dec(tRCD_i) : dec(rcd[b]);
                ras[b] <= opening[b] ? dec(tRAS_i) : dec(ras[b]);
                rc[b]  <= (opening[b] || is_ref) ? dec(tRC_i) : dec(rc[b]);
                rp[b]  <= close_pre[b] ? dec(tRP_i) : close_ap[b] ? dec(tDAL_i) : dec(rp[b]);
            end
        end
    end

`ifdef SDRAM_BANK_TRACKER_ERR_EN
    logic is_mrs, is_self, err_set;
    assign is_mrs  = cs && cmd_i[2:0] == 3'b000;
    assign is_self = cmd_i == 5'b00001;
    assign err_set = (is_act && !act_ok[cmd_bank_i]) ||
                     (is_rw && !rw_ok[cmd_bank_i]) ||
                     (is_pre && !cmd_a10_i && !pre_ok[cmd_bank_i]) ||
                     (is_pre && cmd_a10_i && |ras_busy) ||
                     ((is_ref || is_mrs || is_self) && |active);
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) err_o <= 1'b0;
        else if (err_set) err_o <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_sdram_bank_tracker.sv
// tb_sdram_bank_tracker: directed + random commands scored against an absolute-time bank model.
module tb_sdram_bank_tracker;
    localparam int BANKS = 4;
    localparam int RB    = 13;
    localparam int BW    = 2;
    localparam logic [4:0] C_NOP = 5'b10111, C_ACT = 5'b10011, C_RD = 5'b10101, C_WR = 5'b10100;
    localparam logic [4:0] C_PRE = 5'b10010, C_REF = 5'b10001, C_MRS = 5'b10000, C_BST = 5'b10110;
    localparam logic [4:0] C_DESL = 5'b11111, C_SELF = 5'b00001;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [4:0] cmd = C_NOP;
    logic [BW-1:0] cbank = '0, qbank = '0;
    logic [RB-1:0] crow = '0, qrow = '0;
    logic ca10 = 1'b0;
    logic [3:0] trcd = 4'd3, tras = 4'd5, trp = 4'd2, trc = 4'd7, tdal = 4'd4;
    logic hit, aok, rwok, pok, idle;
    logic [BANKS-1:0] bact;
`ifdef SDRAM_BANK_TRACKER_ERR_EN
    logic err;
`endif

    always #5 clk = ~clk;

    sdram_bank_tracker #(.BANKS(BANKS), .ROW_BITS(RB)) dut (
        .HCLK(clk), .HRESETn(rst_n), .cmd_i(cmd), .cmd_bank_i(cbank), .cmd_row_i(crow),
        .cmd_a10_i(ca10), .tRCD_i(trcd), .tRAS_i(tras), .tRP_i(trp), .tRC_i(trc), .tDAL_i(tdal),
        .q_bank_i(qbank), .q_row_i(qrow), .q_row_hit_o(hit), .q_act_ok_o(aok), .q_rw_ok_o(rwok),
        .q_pre_ok_o(pok), .bank_active_o(bact), .all_idle_o(idle)
`ifdef SDRAM_BANK_TRACKER_ERR_EN
        , .err_o(err)
`endif
    );

    typedef struct {
        bit hit, aok, rwok, pok, idle, err;
        int act;
    } exp_t;
    exp_t sb[$];
    int checks = 0, passed = 0;

    // Model keeps the absolute cycle at which each gated condition becomes true.
    bit m_act[BANKS];
    int m_row[BANKS], rcd_at[BANKS], ras_at[BANKS], rp_at[BANKS], rc_at[BANKS];
    int cyc = 0;
    bit m_err = 0;

    task automatic chk(input string n, input int got, input int want);
        checks++;
        if (got == want) passed++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, got, want, cyc);
    endtask

    function automatic int mx(input int t);
        return t < 1 ? 1 : t;
    endfunction
    function automatic bit m_aok(input int b);
        return !m_act[b] && cyc >= rp_at[b] && cyc >= rc_at[b];
    endfunction
    function automatic bit m_rwok(input int b);
        return m_act[b] && cyc >= rcd_at[b];
    endfunction
    function automatic bit m_pok(input int b);
        return !m_act[b] || cyc >= ras_at[b];
    endfunction

    task automatic model_reset();
        for (int b = 0; b < BANKS; b++) begin
            m_act[b] = 0; m_row[b] = 0; rcd_at[b] = 0; ras_at[b] = 0; rp_at[b] = 0; rc_at[b] = 0;
        end
        m_err = 0;
        cyc = 0;
    endtask

    task automatic step(input logic [4:0] c, input int b, input int r, input bit a10, input int qb, input int qr);
        exp_t e;
        bit bad = 0, any_act = 0, any_ras = 0;
        int amask = 0;
        cmd = c; cbank = BW'(b); crow = RB'(r); ca10 = a10; qbank = BW'(qb); qrow = RB'(qr);
        for (int i = 0; i < BANKS; i++) begin
            if (m_act[i]) amask |= (1 << i);
            any_act |= m_act[i];
            any_ras |= !m_pok(i);
        end
        e.hit = m_act[qb] && m_row[qb] == qr;
        e.aok = m_aok(qb); e.rwok = m_rwok(qb); e.pok = m_pok(qb);
        e.act = amask; e.idle = !any_act; e.err = m_err;
        sb.push_back(e);
        case (c)
            C_ACT: begin
                bad = !m_aok(b);
                m_act[b] = 1; m_row[b] = r;
                rcd_at[b] = cyc + mx(int'(trcd)); ras_at[b] = cyc + mx(int'(tras)); rc_at[b] = cyc + mx(int'(trc));
            end
            C_RD, C_WR: begin
                bad = !m_rwok(b);
                if (a10) begin m_act[b] = 0; rp_at[b] = cyc + mx(int'(tdal)); end
            end
            C_PRE: begin
                bad = a10 ? any_ras : !m_pok(b);
                for (int i = 0; i < BANKS; i++)
                    if (m_act[i] && (a10 || i == b)) begin m_act[i] = 0; rp_at[i] = cyc + mx(int'(trp)); end
            end
            C_REF: begin
                bad = any_act;
                for (int i = 0; i < BANKS; i++) rc_at[i] = cyc + mx(int'(trc));
            end
            C_MRS, C_SELF: bad = any_act;
            default: ;
        endcase
        if (bad) m_err = 1;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    // Asynchronous reset: outputs must take reset values before any clock edge.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_row_hit", hit, 0);
        chk("rst_act_ok", aok, 1);
        chk("rst_rw_ok", rwok, 0);
        chk("rst_pre_ok", pok, 1);
        chk("rst_bank_active", bact, 0);
        chk("rst_all_idle", idle, 1);
`ifdef SDRAM_BANK_TRACKER_ERR_EN
        chk("rst_err", err, 0);
`endif
        model_reset();
        cmd = C_NOP;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("row_hit", hit, e.hit);
                chk("act_ok", aok, e.aok);
                chk("rw_ok", rwok, e.rwok);
                chk("pre_ok", pok, e.pok);
                chk("bank_active", bact, e.act);
                chk("all_idle", idle, e.idle);
`ifdef SDRAM_BANK_TRACKER_ERR_EN
                chk("err", err, e.err);
`endif
            end
        end
    end

    function automatic int prow();
        int k = $urandom_range(3);
        return k == 0 ? 'h155 : k == 1 ? 'h0AA : k == 2 ? 0 : $urandom_range(8191);
    endfunction
    function automatic logic [3:0] rt();
        return $urandom_range(1) ? 4'($urandom_range(4)) : 4'($urandom_range(15));
    endfunction

    initial begin : stim
        int p, b;
        logic [4:0] c;
        do_reset();
        step(C_ACT, 1, 'h155, 0, 1, 'h155);
        repeat (4) step(C_NOP, 0, 0, 0, 1, 'h155);
        step(C_NOP, 0, 0, 0, 1, 'h154);
        step(C_ACT, 0, 7, 0, 0, 7);
        repeat (4) step(C_NOP, 0, 0, 0, 0, 7);
        step(C_PRE, 0, 0, 0, 0, 7);
        repeat (3) step(C_NOP, 0, 0, 0, 0, 7);
        step(C_PRE, 1, 0, 0, 1, 0);
        step(C_ACT, 0, 1, 0, 0, 1);
        step(C_ACT, 2, 2, 0, 2, 2);
        step(C_ACT, 3, 3, 0, 3, 3);
        repeat (8) step(C_NOP, 0, 0, 0, 2, 2);
        step(C_PRE, 1, 0, 1, 2, 2);
        repeat (3) step(C_NOP, 0, 0, 0, 2, 2);
        step(C_ACT, 2, 'h0AA, 0, 2, 'h0AA);
        repeat (9) step(C_NOP, 0, 0, 0, 2, 'h0AA);
        step(C_WR, 2, 0, 1, 2, 'h0AA);
        repeat (5) step(C_NOP, 0, 0, 0, 2, 'h0AA);
        step(C_RD, 3, 0, 0, 3, 0);
        repeat (3) step(C_NOP, 0, 0, 0, 3, 0);
        trc = 4'd0; tras = 4'd0; trcd = 4'd0;
        step(C_ACT, 0, 5, 0, 0, 5);
        step(C_RD, 0, 0, 1, 0, 5);
        step(C_NOP, 0, 0, 0, 0, 5);
        trc = 4'd15;
        step(C_ACT, 3, 9, 0, 3, 9);
        repeat (2) step(C_NOP, 0, 0, 0, 3, 9);
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            if (n % 64 == 0) begin trcd = rt(); tras = rt(); trp = rt(); trc = rt(); tdal = rt(); end
            if (n % 500 == 499) do_reset();
            p = $urandom_range(99);
            c = p < 25 ? C_ACT : p < 35 ? C_RD : p < 45 ? C_WR : p < 65 ? C_PRE : p < 70 ? C_REF :
                p < 73 ? C_MRS : p < 75 ? C_SELF : p < 85 ? C_NOP : p < 92 ? C_DESL : C_BST;
            b = $urandom_range(BANKS - 1);
            step(c, b, prow(), $urandom_range(3) == 0,
                 $urandom_range(1) ? b : $urandom_range(BANKS - 1), prow());
        end
        @(posedge clk);
        #6;
        if (sb.size() != 0) chk("scoreboard_drain", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
